cacheline_arbiter: RTL and testbench

Shares the single 64-bit burst memory port of `mp4` between the instruction cache and the data cache. Accepts whole-cacheline (256-bit) requests from both caches, grants one at a time with round-robin tie-breaking, and serializes each line into a 4-beat burst read or write. Sits between the two caches and the `mem_*` pins of `mp4`.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/line_beat_buffer.sv | 44 ++++
 rtl/cacheline_arbiter.sv | 115 +++++++++++
 tb/tb_cacheline_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the cacheline arbiter between the icache/dcache
// and the single 64-bit burst memory port.
package mem_arb_pkg;

    localparam int LINE_BITS = 256;
    localparam int BEAT_BITS = 64;
    localparam int BEATS     = LINE_BITS / BEAT_BITS;
    localparam int CNT_BITS  = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        DONE
    } arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } grant_t;

endpackage

// File: rtl/line_beat_buffer.sv
// Holds one cacheline plus the beat counter; assembles read bursts beat by beat
// and presents the current write beat from a latched line.
module line_beat_buffer
    import mem_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_line,
    input  logic [LINE_BITS-1:0] line_in,
    input  logic                 clear,
    input  logic                 beat_en,
    input  logic                 capture,
    input  logic [BEAT_BITS-1:0] beat_in,
    output logic [BEAT_BITS-1:0] beat_out,
    output logic                 last_beat,
    output logic [LINE_BITS-1:0] line_out
);

    logic [LINE_BITS-1:0] line;
    logic [CNT_BITS-1:0]  cnt;

    // NOTE: the line register is reset too, so the rdata outputs read 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line <= '0;
            cnt  <= '0;
        end else begin
            if (load_line)
                line <= line_in;
            else if (beat_en && capture)
                line[BEAT_BITS*cnt +: BEAT_BITS] <= beat_in;

            if (clear)
                cnt <= '0;
            else if (beat_en)
                cnt <= cnt + 1'b1;
        end
    end

    assign beat_out  = line[BEAT_BITS*cnt +: BEAT_BITS];
    assign last_beat = (cnt == CNT_BITS'(BEATS - 1));
    assign line_out  = line;

endmodule

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one 64-bit burst memory port between the
// instruction and data caches; each grant moves one whole line in 4 beats.
module cacheline_arbiter
    import mem_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_read,
    input  logic [31:0]          i_addr,
    output logic [LINE_BITS-1:0] i_rdata,
    output logic                 i_resp,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [31:0]          d_addr,
    input  logic [LINE_BITS-1:0] d_wdata,
    output logic [LINE_BITS-1:0] d_rdata,
    output logic                 d_resp,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [31:0]          mem_addr,
    output logic [BEAT_BITS-1:0] mem_wdata,
    input  logic [BEAT_BITS-1:0] mem_rdata,
    input  logic                 mem_resp
);

    arb_state_t           state, next_state;
    grant_t               last_grant, pick;
    logic                 i_req, d_req, grant_fire;
    logic                 in_xfer, in_read, last_beat;
    logic [LINE_BITS-1:0] line_out;
    logic                 unused_addr_bits;

    assign i_req      = i_read;
    assign d_req      = d_read | d_write;
    assign grant_fire = (state == IDLE) && (i_req || d_req);
    assign in_read    = (state == I_RD) || (state == D_RD);
    assign in_xfer    = in_read || (state == D_WR);

    // Tie goes to whichever cache was not served last.
    always_comb begin
        if (i_req && d_req)
            pick = (last_grant == ICACHE) ? DCACHE : ICACHE;
        else if (d_req)
            pick = DCACHE;
        else
            pick = ICACHE;
    end

    // NOTE: non-blocking assignments for all registered state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // NOTE: default assignment first so no path leaves next_state unassigned.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (grant_fire) begin
                    if (pick == ICACHE)
                        next_state = I_RD;
                    else
                        next_state = d_write ? D_WR : D_RD;
                end
            end
            I_RD, D_RD, D_WR: begin
                if (mem_resp && last_beat)
                    next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_read  = (state == I_RD) || (state == D_RD);
        mem_write = (state == D_WR);
        i_resp    = (state == DONE) && (last_grant == ICACHE);
        d_resp    = (state == DONE) && (last_grant == DCACHE);
    end

    // last_grant doubles as the owner of the burst in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr   <= '0;
            last_grant <= ICACHE;
        end else if (grant_fire) begin
            mem_addr   <= (pick == ICACHE) ? {i_addr[31:5], 5'b0} : {d_addr[31:5], 5'b0};
            last_grant <= pick;
        end
    end

    line_beat_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .load_line (grant_fire && (pick == DCACHE) && d_write),
        .line_in   (d_wdata),
        .clear     (grant_fire),
        .beat_en   (in_xfer && mem_resp),
        .capture   (in_read),
        .beat_in   (mem_rdata),
        .beat_out  (mem_wdata),
        .last_beat (last_beat),
        .line_out  (line_out)
    );

    assign i_rdata = line_out;
    assign d_rdata = line_out;

    assign unused_addr_bits = ^{i_addr[4:0], d_addr[4:0]};

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed self-checking bench for cacheline_arbiter: reads, gapped writes,
// round-robin ties, dropped requests, async reset mid-burst, read+write conflict.
module tb_cacheline_arbiter;
    import mem_arb_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_read, d_read, d_write, mem_resp;
    logic [31:0]          i_addr, d_addr;
    logic [LINE_BITS-1:0] d_wdata, i_rdata, d_rdata;
    logic                 i_resp, d_resp, mem_read, mem_write;
    logic [31:0]          mem_addr;
    logic [BEAT_BITS-1:0] mem_wdata, mem_rdata;

    int tests  = 0;
    int failed = 0;

    cacheline_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LINE_BITS-1:0] observed,
                         input logic [LINE_BITS-1:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Four back-to-back beats taken from a full line, low beat first.
    task automatic burst4(input logic [LINE_BITS-1:0] line);
        for (int k = 0; k < BEATS; k++) begin
            mem_resp  = 1'b1;
            mem_rdata = line[BEAT_BITS*k +: BEAT_BITS];
            tick();
        end
        mem_resp  = 1'b0;
        mem_rdata = '0;
    endtask

    localparam logic [LINE_BITS-1:0] L_I = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [LINE_BITS-1:0] L_D = {64'h8888_0000_0000_0008, 64'h7777_0000_0000_0007,
                                            64'h6666_0000_0000_0006, 64'h5555_0000_0000_0005};
    localparam logic [LINE_BITS-1:0] L_W = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    localparam logic [LINE_BITS-1:0] L_X = {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
                                            64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A};

    initial begin
        rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        #12;
        check("rst_mem_read",  mem_read,  1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_addr",  mem_addr,  32'h0);
        check("rst_mem_wdata", mem_wdata, 64'h0);
        check("rst_i_rdata",   i_rdata,   '0);
        check("rst_resp",      {i_resp, d_resp}, 2'b00);
        tick();
        rst = 1'b1;
        tick();

        // mem_resp while idle is ignored
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        check("idle_resp_ignored", {mem_read, mem_write, i_resp, d_resp}, 4'b0000);

        // Tie from reset: dcache first
        i_read = 1'b1; i_addr = 32'h0000_1040;
        d_read = 1'b1; d_addr = 32'h8000_203F;
        tick();
        check("tie1_addr",     mem_addr, 32'h8000_2020);
        check("tie1_mem_read", mem_read, 1'b1);
        burst4(L_D);
        check("tie1_resp",  {i_resp, d_resp}, 2'b01);
        check("tie1_rdata", d_rdata, L_D);
        tick();
        check("tie1_idle", {mem_read, d_resp}, 2'b00);
        // Both still requesting: icache wins this tie
        tick();
        check("tie2_addr", mem_addr, 32'h0000_1040);
        burst4(L_I);
        check("tie2_resp",  {i_resp, d_resp}, 2'b10);
        check("tie2_rdata", i_rdata, L_I);
        tick();
        tick();
        check("tie3_addr", mem_addr, 32'h8000_2020);
        burst4(L_D);
        check("tie3_resp", {i_resp, d_resp}, 2'b01);
        i_read = 1'b0; d_read = 1'b0;
        tick();

        // icache read, back-to-back beats
        i_read = 1'b1; i_addr = 32'h6000_0014;
        tick();
        check("iread_addr", mem_addr, 32'h6000_0000);
        for (int k = 0; k < BEATS; k++) begin
            check("iread_mem_read", {mem_read, mem_write, i_resp}, 3'b100);
            mem_resp  = 1'b1;
            mem_rdata = L_I[BEAT_BITS*k +: BEAT_BITS];
            tick();
        end
        mem_resp = 1'b0;
        check("iread_done",  {mem_read, i_resp, d_resp}, 3'b010);
        check("iread_rdata", i_rdata, L_I);
        i_read = 1'b0;
        tick();
        check("iread_resp_pulse", i_resp, 1'b0);

        // dcache write with gaps
        d_write = 1'b1; d_addr = 32'h1234_5678; d_wdata = L_W;
        tick();
        check("wr_addr",  mem_addr, 32'h1234_5660);
        check("wr_flags", {mem_write, mem_read}, 2'b10);
        check("wr_beat0", mem_wdata, 64'hAAAA_AAAA_AAAA_AAAA);
        tick();
        check("wr_beat0_gap", mem_wdata, 64'hAAAA_AAAA_AAAA_AAAA);
        mem_resp = 1'b1; tick(); mem_resp = 1'b0;
        check("wr_beat1", mem_wdata, 64'hBBBB_BBBB_BBBB_BBBB);
        tick();
        check("wr_beat1_gap", mem_wdata, 64'hBBBB_BBBB_BBBB_BBBB);
        mem_resp = 1'b1; tick();
        check("wr_beat2", mem_wdata, 64'hCCCC_CCCC_CCCC_CCCC);
        tick(); mem_resp = 1'b0;
        check("wr_beat3", mem_wdata, 64'hDDDD_DDDD_DDDD_DDDD);
        tick();
        check("wr_beat3_gap", {mem_write, d_resp, mem_wdata}, {2'b10, 64'hDDDD_DDDD_DDDD_DDDD});
        mem_resp = 1'b1; tick(); mem_resp = 1'b0;
        check("wr_done", {mem_write, d_resp, i_resp}, 3'b010);
        d_write = 1'b0;
        tick();

        // Dropped icache request during beat 2
        i_read = 1'b1; i_addr = 32'h0000_0100;
        tick();
        for (int k = 0; k < BEATS; k++) begin
            if (k == 2) i_read = 1'b0;
            mem_resp  = 1'b1;
            mem_rdata = L_X[BEAT_BITS*k +: BEAT_BITS];
            tick();
        end
        mem_resp = 1'b0;
        check("drop_resp",  i_resp, 1'b1);
        check("drop_rdata", i_rdata, L_X);
        tick();
        check("drop_after", {i_resp, mem_read}, 2'b00);
        tick();
        check("drop_once", i_resp, 1'b0);

        // Reset mid-burst after beat 1
        d_read = 1'b1; d_addr = 32'h0000_0200;
        tick();
        mem_resp = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000; tick();
        mem_resp = 1'b1; mem_rdata = 64'hFFFF_1111_FFFF_1111; tick();
        mem_resp = 1'b0;
        rst = 1'b0;
        #1;
        check("rstmid_mem_read", mem_read, 1'b0);
        check("rstmid_outs", {mem_write, i_resp, d_resp, mem_addr, mem_wdata}, '0);
        check("rstmid_rdata", d_rdata, '0);
        tick();
        rst = 1'b1;
        tick();
        check("rstmid_regrant", {mem_read, mem_addr}, {1'b1, 32'h0000_0200});
        burst4(L_X);
        check("rstmid_resp",  d_resp, 1'b1);
        check("rstmid_rdata2", d_rdata, L_X);
        d_read = 1'b0;
        tick();

        // Read+write conflict resolves as a write
        d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_0300; d_wdata = L_D;
        tick();
        check("rw_flags", {mem_write, mem_read}, 2'b10);
        check("rw_beat0", mem_wdata, L_D[63:0]);
        burst4(L_I);
        check("rw_done", {d_resp, mem_write}, 2'b10);
        d_read = 1'b0; d_write = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
